operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: operand/data width.
REQ-002 The block SHALL have parameter NUM_REGS, default 32: architectural registers; index width = log2(NUM_REGS) = 5.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 The block SHALL have port InValid, input, 1: upstream instruction valid.
REQ-007 The block SHALL have port InReady, output, 1: block accepts instruction this cycle.
REQ-008 The block SHALL have ports InRs and InRt, input, 5 each: source register indices.
REQ-009 The block SHALL have port InRd, input, 5: destination index; 0 means no destination.
REQ-010 The block SHALL have port InPayload, input, 32: opaque instruction word, passed through.
REQ-011 The block SHALL have ports ReadRegister1 and ReadRegister2, output, 5 each: register-file read addresses, driven combinationally from InRs/InRt.
REQ-012 The block SHALL have ports ReadData1 and ReadData2, input, DATA_W each: register-file asynchronous read data.
REQ-013 The block SHALL have ports WbEnable (input, 1), WbRegister (input, 5) and WbData (input, DATA_W): the same write-back bus that drives the register file write port.
REQ-014 The block SHALL have ports OutValid (output, 1) and OutReady (input, 1): downstream handshake.
REQ-015 The block SHALL have ports OutOpA and OutOpB (output, DATA_W each), OutDest (output, 5) and OutPayload (output, 32): the registered issue bundle.

Function
REQ-016 The block SHALL keep a busy bit per register; bit 0 SHALL be constant 0.
REQ-017 The operand for source s SHALL be 0 if s==0; else WbData if WbEnable and WbRegister==s; else register-file data.
REQ-018 Source s SHALL be hazarded when s!=0, busy[s]=1, and not (WbEnable and WbRegister==s).
REQ-019 The destination SHALL be hazarded (WAW) when InRd!=0, busy[InRd]=1, and not (WbEnable and WbRegister==InRd).
REQ-020 InReady SHALL equal no hazard on InRs, InRt and InRd, and (OutValid==0 or OutReady==1); it SHALL NOT depend on InValid.
REQ-021 Accept SHALL be InValid and InReady; on accept the output bundle SHALL load on the same edge, giving OutValid=1 one cycle after accept.
REQ-022 OutValid SHALL clear on an edge where OutValid and OutReady are 1 and there is no accept; the bundle SHALL hold stable while OutValid=1 and OutReady=0.
REQ-023 On accept with InRd!=0, the block SHALL set busy[InRd].
REQ-024 WbEnable with WbRegister!=0 SHALL clear busy[WbRegister]; WbRegister==0 SHALL have no effect.
REQ-025 When a set and a clear target the same register on the same edge, the set SHALL win.
REQ-026 A write-back to a non-busy register SHALL be harmless: the busy bit stays 0 and no error is raised.
REQ-027 Back-to-back accepts SHALL sustain 1 instruction per cycle when there is no hazard and OutReady=1.

Reset
REQ-028 On reset the block SHALL clear all busy bits and force OutValid=0, OutOpA=0, OutOpB=0, OutDest=0 and OutPayload=0.
REQ-029 Reset SHALL take priority over accept and write-back on the same edge; a held bundle SHALL be discarded.
REQ-030 InReady SHALL be 0 while reset is high.

Structure
REQ-031 DATA_W, NUM_REGS, the register index width and the zero-register constant SHALL live in a shared package, turbo_pkg.
REQ-032 The busy-bit array, including set/clear priority and the hazard lookups, SHALL be a sub-module named reg_scoreboard.
REQ-033 Forwarding muxes and the output register SHALL stay in operand_fetch.

Verification
REQ-034 The bench SHALL check: rf[3]=0x11, rf[4]=0x22; issue Rs=3, Rt=4, Rd=5 with OutReady=1 -> next cycle OutValid=1, OutOpA=0x11, OutOpB=0x22, OutDest=5, busy[5]=1.
REQ-035 The bench SHALL check: busy[5]=1, then issue Rs=5 -> InReady=0; next cycle Wb(5, 0xABCD) -> InReady=1 in that same cycle, and OutOpA=0xABCD one cycle later.
REQ-036 The bench SHALL check: issue Rd=7 in the same cycle as Wb(7) while busy[7]=1 -> busy[7] stays 1 after the edge.
REQ-037 The bench SHALL check: hold OutReady=0 for 3 cycles with OutValid=1 -> bundle unchanged and InReady=0; release -> the next instruction issues with no bubble.
REQ-038 The bench SHALL check: Rs=0, Rt=0 with rf[0]=0xFFFF and Wb(0, 0x1234) active -> OutOpA=OutOpB=0; busy stays all 0.
REQ-039 The bench SHALL check: reset asserted for one cycle while OutValid=1 and busy[9]=1 -> OutValid=0 and all busy bits 0 after the edge.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared widths and constants for the issue front end.
//   DATA_W     : operand / register data width
//   NUM_REGS   : number of architectural registers
//   REG_IDX_W  : register index width
//   PAYLOAD_W  : opaque instruction word width
//   ZERO_REG   : hard-wired zero register index
package turbo_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
    localparam int unsigned PAYLOAD_W = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

endpackage : turbo_pkg

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per architectural register.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   i_set_en / i_set_idx    : mark a register busy (issued instruction)
//   i_clr_en / i_clr_idx    : write-back clears a register's busy bit
//   i_rs, i_rt, i_rd        : indices to look up for RAW / WAW hazards
//   o_hazard_c              : combinational, any of rs/rt/rd is hazarded
module reg_scoreboard
    import turbo_pkg::*;
#(
    parameter int unsigned NUM_REGS = turbo_pkg::NUM_REGS,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set_en,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic [IDX_W-1:0] i_rs,
    input  logic [IDX_W-1:0] i_rt,
    input  logic [IDX_W-1:0] i_rd,
    output logic             o_hazard_c
);

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

    // Register 0 never holds state, so only bits 1..NUM_REGS-1 exist.
    logic [NUM_REGS-1:1] r_busy;
    logic [NUM_REGS-1:1] w_busy_nxt;
    logic [NUM_REGS-1:0] w_busy;
    logic                w_haz_rs;
    logic                w_haz_rt;
    logic                w_haz_rd;

    assign w_busy = {r_busy, 1'b0};

    // Next busy vector; a set on the same register as a clear wins.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (i_set_en && (i_set_idx == IDX_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (i_clr_en && (i_clr_idx == IDX_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A write-back landing this cycle resolves the hazard (it is forwarded).
    assign w_haz_rs = (i_rs != ZERO_IDX) && w_busy[i_rs] &&
                      !(i_clr_en && (i_clr_idx == i_rs));
    assign w_haz_rt = (i_rt != ZERO_IDX) && w_busy[i_rt] &&
                      !(i_clr_en && (i_clr_idx == i_rt));
    assign w_haz_rd = (i_rd != ZERO_IDX) && w_busy[i_rd] &&
                      !(i_clr_en && (i_clr_idx == i_rd));

    assign o_hazard_c = w_haz_rs || w_haz_rt || w_haz_rd;

endmodule : reg_scoreboard

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: reads the register file, forwards the
// current write-back, blocks on RAW/WAW hazards and registers the issue
// bundle behind a valid/ready handshake.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   InValid/InReady                : upstream handshake
//   InRs, InRt, InRd, InPayload    : incoming instruction fields
//   ReadRegister1/2, ReadData1/2   : register-file async read port
//   WbEnable, WbRegister, WbData   : write-back bus
//   OutValid/OutReady              : downstream handshake
//   OutOpA, OutOpB, OutDest, OutPayload : registered issue bundle
module operand_fetch
    import turbo_pkg::*;
#(
    parameter int unsigned DATA_W   = turbo_pkg::DATA_W,
    parameter int unsigned NUM_REGS = turbo_pkg::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [$clog2(NUM_REGS)-1:0] InRs,
    input  logic [$clog2(NUM_REGS)-1:0] InRt,
    input  logic [$clog2(NUM_REGS)-1:0] InRd,
    input  logic [PAYLOAD_W-1:0]     InPayload,
    output logic [$clog2(NUM_REGS)-1:0] ReadRegister1,
    output logic [$clog2(NUM_REGS)-1:0] ReadRegister2,
    input  logic [DATA_W-1:0]        ReadData1,
    input  logic [DATA_W-1:0]        ReadData2,
    input  logic                     WbEnable,
    input  logic [$clog2(NUM_REGS)-1:0] WbRegister,
    input  logic [DATA_W-1:0]        WbData,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_W-1:0]        OutOpA,
    output logic [DATA_W-1:0]        OutOpB,
    output logic [$clog2(NUM_REGS)-1:0] OutDest,
    output logic [PAYLOAD_W-1:0]     OutPayload
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

    logic                 w_hazard;
    logic                 w_accept;
    logic                 w_set_en;
    logic [DATA_W-1:0]    w_op_a;
    logic [DATA_W-1:0]    w_op_b;

    logic                 r_valid;
    logic [DATA_W-1:0]    r_op_a;
    logic [DATA_W-1:0]    r_op_b;
    logic [IDX_W-1:0]     r_dest;
    logic [PAYLOAD_W-1:0] r_payload;

    assign ReadRegister1 = InRs;
    assign ReadRegister2 = InRt;

    assign w_set_en = w_accept && (InRd != ZERO_IDX);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .i_set_en   (w_set_en),
        .i_set_idx  (InRd),
        .i_clr_en   (WbEnable),
        .i_clr_idx  (WbRegister),
        .i_rs       (InRs),
        .i_rt       (InRt),
        .i_rd       (InRd),
        .o_hazard_c (w_hazard)
    );

    // Operand select: zero register, then same-cycle write-back, then RF.
    always_comb begin
        w_op_a = ReadData1;
        w_op_b = ReadData2;
        if (InRs == ZERO_IDX) begin
            w_op_a = '0;
        end else if (WbEnable && (WbRegister == InRs)) begin
            w_op_a = WbData;
        end
        if (InRt == ZERO_IDX) begin
            w_op_b = '0;
        end else if (WbEnable && (WbRegister == InRt)) begin
            w_op_b = WbData;
        end
    end

    // Ready is independent of InValid so upstream may wait on it.
    assign InReady  = !reset && !w_hazard && (!r_valid || OutReady);
    assign w_accept = InValid && InReady;

    // Issue bundle register; holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_dest    <= '0;
            r_payload <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op_a    <= w_op_a;
            r_op_b    <= w_op_b;
            r_dest    <= InRd;
            r_payload <= InPayload;
        end else if (OutReady) begin
            r_valid   <= 1'b0;
        end
    end

    assign OutValid   = r_valid;
    assign OutOpA     = r_op_a;
    assign OutOpB     = r_op_b;
    assign OutDest    = r_dest;
    assign OutPayload = r_payload;

endmodule : operand_fetch
